// File: rtl/decision_buffer_pkg.sv
// Shared types and constants for the fraud decision buffer.
package decision_buffer_pkg;

  localparam int DEC_WIDTH        = 32;
  localparam int DEFAULT_DEPTH    = 16;
  localparam int DEFAULT_ID_WIDTH = 16;

  typedef struct packed {
    logic [DEFAULT_ID_WIDTH-1:0] id;
    logic                        fraud;
  } entry_t;

  function automatic logic [31:0] satInc(input logic [31:0] value, input logic enable);
    return (enable && (value != 32'hFFFF_FFFF)) ? value + 32'd1 : value;
  endfunction

endpackage

// File: rtl/decision_fifo.sv
// Synchronous first-word-fall-through FIFO with registered full/empty flags.
module decision_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE  = (AW+1)'(1);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wrPtr_q, rdPtr_q;
  logic [AW:0]      count_q, count_d;
  logic             full_q, empty_q;

  always_comb begin
    count_d = count_q;
    if (i_push && !i_pop)
      count_d = count_q + ONE;
    else if (!i_push && i_pop)
      count_d = count_q - ONE;
  end

  // Storage is not reset; the pointers alone decide what is visible.
  always_ff @(posedge i_clk) begin
    if (i_push)
      mem_q[wrPtr_q] <= i_data;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (i_push)
        wrPtr_q <= wrPtr_q + 1'b1;
      if (i_pop)
        rdPtr_q <= rdPtr_q + 1'b1;
      count_q <= count_d;
      full_q  <= (count_d == FULL);
      empty_q <= (count_d == '0);
    end
  end

  assign o_data  = mem_q[rdPtr_q];
  assign o_full  = full_q;
  assign o_empty = empty_q;

endmodule

// File: rtl/decision_buffer.sv
// Buffers fraud decisions tagged with a sequence ID, with statistics,
// a sticky overflow flag and a per-fraud interrupt pulse.
module decision_buffer
  import decision_buffer_pkg::*;
#(
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int ID_WIDTH = DEFAULT_ID_WIDTH
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [DEC_WIDTH-1:0] i_data,
  input  logic                 i_data_valid,
  output logic [ID_WIDTH-1:0]  o_id,
  output logic                 o_fraud,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_full,
  output logic                 o_empty,
  output logic                 o_overflow,
  output logic [31:0]          o_txn_count,
  output logic [31:0]          o_fraud_count,
  input  logic                 i_clear_stats,
  output logic                 o_irq
);

  logic                pop, accept, drop, isFraud;
  logic                fifoFull, fifoEmpty;
  logic [ID_WIDTH:0]   headEntry;
  logic [ID_WIDTH-1:0] seqId_q, seqId_d;
  logic [31:0]         txnCount_q, txnCount_d, fraudCount_q, fraudCount_d;
  logic                overflow_q, overflow_d, irq_q;

  // A full buffer can still take a word when the head leaves in the same cycle.
  assign isFraud = |i_data;
  assign pop     = !fifoEmpty && i_ready;
  assign accept  = i_data_valid && (!fifoFull || pop);
  assign drop    = i_data_valid && !accept;

  decision_fifo #(
    .WIDTH (ID_WIDTH + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (accept),
    .i_data  ({seqId_q, isFraud}),
    .i_pop   (pop),
    .o_data  (headEntry),
    .o_full  (fifoFull),
    .o_empty (fifoEmpty)
  );

  // A clear that lands on an accept restarts the stats from this cycle's events.
  always_comb begin
    seqId_d      = accept ? seqId_q + 1'b1 : seqId_q;
    txnCount_d   = satInc(i_clear_stats ? 32'd0 : txnCount_q, accept);
    fraudCount_d = satInc(i_clear_stats ? 32'd0 : fraudCount_q, accept && isFraud);
    overflow_d   = (!i_clear_stats && overflow_q) || drop;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      seqId_q      <= '0;
      txnCount_q   <= '0;
      fraudCount_q <= '0;
      overflow_q   <= 1'b0;
      irq_q        <= 1'b0;
    end else begin
      seqId_q      <= seqId_d;
      txnCount_q   <= txnCount_d;
      fraudCount_q <= fraudCount_d;
      overflow_q   <= overflow_d;
      irq_q        <= accept && isFraud;
    end
  end

  assign o_valid       = !fifoEmpty;
  assign o_empty       = fifoEmpty;
  assign o_full        = fifoFull;
  assign o_id          = fifoEmpty ? '0 : headEntry[ID_WIDTH:1];
  assign o_fraud       = !fifoEmpty && headEntry[0];
  assign o_overflow    = overflow_q;
  assign o_txn_count   = txnCount_q;
  assign o_fraud_count = fraudCount_q;
  assign o_irq         = irq_q;

endmodule

// File: tb/tb_decision_buffer.sv
// Self-checking bench for decision_buffer: vector table, directed corner
// sequences and random traffic against a queue-based reference model.
module tb_decision_buffer;
  import decision_buffer_pkg::*;

  localparam int DEPTH = 16;

  logic        i_clk = 1'b0;
  logic        i_rst_n, i_data_valid, i_ready, i_clear_stats;
  logic [31:0] i_data;
  logic [15:0] o_id;
  logic        o_fraud, o_valid, o_full, o_empty, o_overflow, o_irq;
  logic [31:0] o_txn_count, o_fraud_count;

  int compared   = 0;
  int mismatched = 0;

  entry_t          modelQ[$];
  int unsigned     modelSeq;
  longint unsigned modelTxn, modelFraud;
  bit              modelOvf, modelIrq;

  typedef struct {
    bit          rstN, valid, ready, clear;
    logic [31:0] data;
    bit          expValid;
    int          expId;
    bit          expFraud, expIrq;
    int          expTxn, expFraudCnt;
  } vec_t;

  vec_t vecs[9];

  decision_buffer #(.DEPTH(DEPTH), .ID_WIDTH(16)) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_data        (i_data),
    .i_data_valid  (i_data_valid),
    .o_id          (o_id),
    .o_fraud       (o_fraud),
    .o_valid       (o_valid),
    .i_ready       (i_ready),
    .o_full        (o_full),
    .o_empty       (o_empty),
    .o_overflow    (o_overflow),
    .o_txn_count   (o_txn_count),
    .o_fraud_count (o_fraud_count),
    .i_clear_stats (i_clear_stats),
    .o_irq         (o_irq)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference behaviour: one clock edge applied to a queue of entries.
  task automatic modelEdge(input bit rstN, valid, ready, clear, input logic [31:0] data);
    bit pop, acc, fr;
    entry_t e;
    if (!rstN) begin
      modelQ.delete();
      modelSeq = 0; modelTxn = 0; modelFraud = 0; modelOvf = 0; modelIrq = 0;
      return;
    end
    pop = (modelQ.size() > 0) && ready;
    acc = valid && ((modelQ.size() < DEPTH) || pop);
    fr  = (data != 0);
    if (clear) begin
      modelTxn = 0; modelFraud = 0; modelOvf = 0;
    end
    if (pop) void'(modelQ.pop_front());
    if (acc) begin
      e.id = modelSeq[15:0];
      e.fraud = fr;
      modelQ.push_back(e);
      modelSeq = (modelSeq + 1) % 65536;
      if (modelTxn < 64'hFFFF_FFFF) modelTxn++;
      if (fr && modelFraud < 64'hFFFF_FFFF) modelFraud++;
    end
    if (valid && !acc) modelOvf = 1;
    modelIrq = acc && fr;
  endtask

  task automatic checkOutput();
    bit ne;
    ne = modelQ.size() > 0;
    check("valid", o_valid, ne);
    check("empty", o_empty, !ne);
    check("full", o_full, modelQ.size() == DEPTH);
    check("id", o_id, ne ? modelQ[0].id : 0);
    check("fraud", o_fraud, ne ? modelQ[0].fraud : 0);
    check("overflow", o_overflow, modelOvf);
    check("irq", o_irq, modelIrq);
    check("txn_count", o_txn_count, modelTxn);
    check("fraud_count", o_fraud_count, modelFraud);
  endtask

  task automatic applyStimulus(input bit rstN, valid, ready, clear, input logic [31:0] data);
    i_rst_n = rstN; i_data_valid = valid; i_ready = ready;
    i_clear_stats = clear; i_data = data;
    @(posedge i_clk);
    modelEdge(rstN, valid, ready, clear, data);
    #1;
    checkOutput();
  endtask

  task automatic doReset();
    applyStimulus(0, 0, 0, 0, 0);
  endtask

  initial begin
    int readyPct;
    i_rst_n = 0; i_data_valid = 0; i_ready = 0; i_clear_stats = 0; i_data = 0;

    //              rst v r c data           vld id fr irq txn frc
    vecs[0] = '{0, 0, 0, 0, 32'h0,         0, 0, 0, 0, 0, 0};
    vecs[1] = '{1, 1, 0, 0, 32'h1,         1, 0, 1, 1, 1, 1};
    vecs[2] = '{1, 0, 0, 0, 32'h0,         1, 0, 1, 0, 1, 1};
    vecs[3] = '{1, 1, 0, 0, 32'h0,         1, 0, 1, 0, 2, 1};
    vecs[4] = '{1, 0, 1, 0, 32'h0,         1, 1, 0, 0, 2, 1};
    vecs[5] = '{1, 0, 1, 0, 32'h0,         0, 0, 0, 0, 2, 1};
    vecs[6] = '{1, 1, 1, 0, 32'h8000_0000, 1, 2, 1, 1, 3, 2};
    vecs[7] = '{1, 1, 0, 1, 32'h7,         1, 2, 1, 1, 1, 1};
    vecs[8] = '{0, 1, 0, 0, 32'h9,         0, 0, 0, 0, 0, 0};

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].rstN, vecs[i].valid, vecs[i].ready, vecs[i].clear, vecs[i].data);
      check($sformatf("vec%0d valid", i), o_valid, vecs[i].expValid);
      check($sformatf("vec%0d id", i), o_id, vecs[i].expId);
      check($sformatf("vec%0d fraud", i), o_fraud, vecs[i].expFraud);
      check($sformatf("vec%0d irq", i), o_irq, vecs[i].expIrq);
      check($sformatf("vec%0d txn", i), o_txn_count, vecs[i].expTxn);
      check($sformatf("vec%0d fraudcnt", i), o_fraud_count, vecs[i].expFraudCnt);
    end

    // Fill past capacity, then drain in order and clear the sticky flag.
    doReset();
    for (int i = 0; i < 17; i++) begin
      applyStimulus(1, 1, 0, 0, 0);
      if (i == 14) check("fill full early", o_full, 0);
      if (i == 15) check("fill full", o_full, 1);
      if (i == 15) check("fill no overflow", o_overflow, 0);
    end
    check("fill overflow", o_overflow, 1);
    check("fill txn", o_txn_count, 16);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("drain id%0d", i), o_id, i);
      applyStimulus(1, 0, 1, 0, 0);
    end
    check("drain empty", o_empty, 1);
    applyStimulus(1, 0, 0, 1, 0);
    check("clear overflow", o_overflow, 0);
    check("clear txn", o_txn_count, 0);

    // Simultaneous push and pop while full.
    doReset();
    for (int i = 0; i < 16; i++) applyStimulus(1, 1, 0, 0, 0);
    applyStimulus(1, 1, 1, 0, 5);
    check("pp overflow", o_overflow, 0);
    check("pp full", o_full, 1);
    check("pp fraudcnt", o_fraud_count, 1);
    check("pp txn", o_txn_count, 17);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("pp drain id%0d", i), o_id, i + 1);
      if (i == 15) check("pp last fraud", o_fraud, 1);
      applyStimulus(1, 0, 1, 0, 0);
    end

    // Head held stable under a stalled consumer.
    doReset();
    applyStimulus(1, 1, 0, 0, 3);
    applyStimulus(1, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 0, 0, 0, 0);
      check("stall id", o_id, 0);
      check("stall fraud", o_fraud, 1);
    end
    applyStimulus(1, 0, 1, 0, 0);
    check("stall pop1 id", o_id, 1);
    applyStimulus(1, 0, 1, 0, 0);
    check("stall empty", o_empty, 1);

    // Clear colliding with a fraud accept.
    doReset();
    for (int i = 0; i < 7; i++) applyStimulus(1, 1, 1, 0, (i < 3) ? i + 1 : 0);
    check("pre-clear txn", o_txn_count, 7);
    check("pre-clear fraud", o_fraud_count, 3);
    applyStimulus(1, 1, 0, 1, 32'hA);
    check("collide txn", o_txn_count, 1);
    check("collide fraud", o_fraud_count, 1);
    check("collide overflow", o_overflow, 0);

    // Reset in the middle of a stream.
    doReset();
    for (int i = 0; i < 4; i++) applyStimulus(1, 1, 0, 0, i);
    applyStimulus(0, 1, 0, 0, 1);
    check("rst valid", o_valid, 0);
    check("rst txn", o_txn_count, 0);
    check("rst fraud", o_fraud_count, 0);
    applyStimulus(1, 1, 0, 0, 0);
    check("rst next id", o_id, 0);
    check("rst next valid", o_valid, 1);

    // Random traffic with a varying consumer rate.
    doReset();
    for (int i = 0; i < 800; i++) begin
      if (i % 100 == 0) readyPct = $urandom_range(10, 90);
      applyStimulus($urandom_range(0, 149) != 0,
                    $urandom_range(0, 2) != 0,
                    $urandom_range(0, 99) < readyPct,
                    $urandom_range(0, 39) == 0,
                    $urandom_range(0, 1) ? $urandom : 32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/decision_buffer.md
DECISION_BUFFER -- requirements
Module: decision_buffer

Interface
REQ-001 Parameter DEPTH, default 16, SHALL be the number of decision entries held (power of two, minimum 2).
REQ-002 Parameter ID_WIDTH, default 16, SHALL be the width of the transaction sequence ID attached to each entry.
REQ-003 Port i_clk  input  1  SHALL be the single clock; all logic on rising edge.
REQ-004 Port i_rst_n  input  1  SHALL be the reset: synchronous, active-low.
REQ-005 Port i_data  input  32  SHALL be the decision word from the upstream max-finding stage.
REQ-006 Port i_data_valid  input  1  SHALL be a one-cycle qualifier for i_data; there is no backpressure upstream.
REQ-007 Port o_id  output  ID_WIDTH  SHALL be the sequence ID of the head entry.
REQ-008 Port o_fraud  output  1  SHALL be the fraud flag of the head entry.
REQ-009 Port o_valid  output  1  SHALL indicate the head entry is valid.
REQ-010 Port i_ready  input  1  SHALL be the consumer accept; a pop occurs when o_valid && i_ready.
REQ-011 Ports o_full, o_empty  output  1 each  SHALL give the registered occupancy state.
REQ-012 Port o_overflow  output  1  SHALL be a sticky flag for a dropped input.
REQ-013 Ports o_txn_count, o_fraud_count  output  32 each  SHALL count accepted entries and accepted fraud entries.
REQ-014 Port i_clear_stats  input  1  SHALL clear both counters and o_overflow.
REQ-015 Port o_irq  output  1  SHALL pulse for one cycle per accepted fraud entry.

Function
REQ-016 Fraud flag SHALL be 1 when i_data != 0, else 0.
REQ-017 An input SHALL be accepted when i_data_valid && (!o_full || pop in the same cycle).
REQ-018 Each accepted entry SHALL store {ID, fraud}; ID = the internal sequence counter, which increments by 1 per accepted entry and wraps from 2^ID_WIDTH-1 to 0.
REQ-019 Latency: an entry accepted at edge N on an empty buffer SHALL present o_valid=1 with its data after edge N (first-word fall-through, registered).
REQ-020 While o_valid && !i_ready, o_id and o_fraud SHALL be held stable.
REQ-021 Order SHALL be strict FIFO; occupancy SHALL be unchanged on a simultaneous push and pop.
REQ-022 When full and not popping, i_data_valid SHALL drop the input, set o_overflow, and leave the ID and counters unchanged.
REQ-023 o_full SHALL be 1 at occupancy DEPTH, and o_empty SHALL be 1 at occupancy 0; o_valid SHALL equal !o_empty.
REQ-024 Counters SHALL saturate at 32'hFFFFFFFF.
REQ-025 When i_clear_stats coincides with an accept, counters SHALL take 0 plus that cycle's increment, and o_overflow SHALL take that cycle's drop status.
REQ-026 o_irq SHALL be high in the cycle after the edge that accepts a fraud entry; back-to-back fraud accepts SHALL give back-to-back pulses.
REQ-027 i_clear_stats SHALL NOT affect buffer contents or the sequence ID.

Reset
REQ-028 While i_rst_n=0 at an edge, the block SHALL flush the buffer and set the following: o_valid=0, o_empty=1, o_full=0, o_id=0, o_fraud=0, o_overflow=0, o_irq=0, both counters 0, sequence ID 0.
REQ-029 Reset mid-operation SHALL discard all held entries; an i_data_valid in the reset cycle SHALL be ignored.

Structure
REQ-030 A shared package SHALL hold DEC_WIDTH=32, the default DEPTH/ID_WIDTH, and the entry record type {id, fraud}.
REQ-031 Storage SHALL be one sub-module, decision_fifo (synchronous FWFT FIFO with push/pop/full/empty); counters, ID and IRQ logic SHALL live in decision_buffer.

Verification
REQ-032 Single entry: reset, i_data=1 valid, i_ready=0 -> next cycle o_valid=1, o_id=0, o_fraud=1, o_irq=1 for one cycle, o_fraud_count=1, o_txn_count=1.
REQ-033 Fill/overflow: 17 inputs of 0 with i_ready=0 -> o_full=1 after 16, 17th dropped, o_overflow=1, o_txn_count=16; draining yields IDs 0..15 in order.
REQ-034 Full with simultaneous push/pop: at full, i_ready=1 and i_data=5 valid -> accepted with ID 16, o_overflow stays 0, occupancy stays 16, o_fraud_count increments.
REQ-035 Stall hold: two entries queued, i_ready low for 5 cycles -> head stable; then i_ready=1 -> entries pop on consecutive cycles, then o_empty=1.
REQ-036 Clear collision: counters at 7/3 and i_clear_stats plus fraud accept in the same cycle -> counters become 1/1 and o_overflow=0.
REQ-037 Reset mid-stream: 4 entries queued, i_rst_n=0 for one cycle -> o_valid=0, counters 0, next accepted entry has ID 0.
